// File: rtl/zap_fetch_queue_if.sv
// Handshake/bus bundle for the decoupled fetch queue. It carries the
// stall/clear controls, the cache-side fetch inputs and the decode-side
// head outputs.
interface zap_fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int PRED_W = 33
);
    localparam int CW = $clog2(DEPTH) + 1;

    // pipeline control
    logic              i_clear_from_writeback;
    logic              i_data_stall;
    logic              i_clear_from_alu;
    logic              i_stall_from_shifter;
    logic              i_stall_from_issue;
    logic              i_stall_from_decode;
    logic              i_clear_from_decode;

    // cache / MMU side
    logic [31:0]       i_pc_ff;
    logic              i_cpsr_ff_t;
    logic [31:0]       i_instruction;
    logic              i_valid;
    logic              i_instr_abort;
    logic [1:0]        i_taken;
    logic [PRED_W-1:0] i_pred;

    // decode side (head of queue) and back-pressure
    logic              o_fetch_hold;
    logic [CW-1:0]     o_count;
    logic              o_valid;
    logic [31:0]       o_instruction;
    logic              o_instr_abort;
    logic [31:0]       o_pc_ff;
    logic [31:0]       o_pc_plus_8_ff;
    logic [1:0]        o_taken;
    logic [PRED_W-1:0] o_pred;

    modport master (
        output i_clear_from_writeback, i_data_stall, i_clear_from_alu,
               i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode,
               i_clear_from_decode, i_pc_ff, i_cpsr_ff_t, i_instruction,
               i_valid, i_instr_abort, i_taken, i_pred,
        input  o_fetch_hold, o_count, o_valid, o_instruction, o_instr_abort,
               o_pc_ff, o_pc_plus_8_ff, o_taken, o_pred
    );

    modport slave (
        input  i_clear_from_writeback, i_data_stall, i_clear_from_alu,
               i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode,
               i_clear_from_decode, i_pc_ff, i_cpsr_ff_t, i_instruction,
               i_valid, i_instr_abort, i_taken, i_pred,
        output o_fetch_hold, o_count, o_valid, o_instruction, o_instr_abort,
               o_pc_ff, o_pc_plus_8_ff, o_taken, o_pred
    );
endinterface

// File: rtl/zap_fetch_queue.sv
// Decoupled instruction fetch queue: buffers DEPTH fetched instructions with
// PC, PC+N, prediction state and abort tag. Thumb halfword selection and
// BKPT tagging happen on enqueue; the head entry falls through to decode.
module zap_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PRED_W = 33
) (
    input  logic               i_clk,
    input  logic               i_reset,
    zap_fetch_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]       instr;
        logic              abort;
        logic [31:0]       pc;
        logic [31:0]       pc_n;
        logic [1:0]        taken;
        logic [PRED_W-1:0] pred;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          sleep_q, sleep_d;

    logic          any_stall;
    logic          flush;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    entry_t        entry_d;
    entry_t        head;
    logic [15:0]   sel_half;
    logic          bkpt_arm;
    logic          bkpt_thumb;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Clear priority: writeback always wins; the ALU clear is masked by a data
    // stall; the decode clear only acts when nothing downstream is stalled.
    assign any_stall = bus.i_data_stall | bus.i_stall_from_shifter |
                       bus.i_stall_from_issue | bus.i_stall_from_decode;
    assign flush = bus.i_clear_from_writeback |
                   (!bus.i_data_stall & bus.i_clear_from_alu) |
                   (!any_stall & bus.i_clear_from_decode);

    // Push ignores stalls so the fetch side keeps filling while decode waits.
    assign pop  = !flush & !any_stall & !empty;
    assign push = !flush & bus.i_valid & !sleep_q & !full;

    // Entry formation: halfword select for PC[1], PC+4/8, BKPT detection.
    always_comb begin
        sel_half   = bus.i_pc_ff[1] ? bus.i_instruction[31:16] : bus.i_instruction[15:0];
        bkpt_arm   = !bus.i_cpsr_ff_t && (bus.i_instruction[31:20] == 12'hE12) &&
                     (bus.i_instruction[7:4] == 4'h7);
        bkpt_thumb = bus.i_cpsr_ff_t && (sel_half[15:8] == 8'hBE);
        entry_d.instr = bus.i_pc_ff[1] ? {16'h0000, bus.i_instruction[31:16]}
                                       : bus.i_instruction;
        entry_d.abort = bus.i_instr_abort | bkpt_arm | bkpt_thumb;
        entry_d.pc    = bus.i_pc_ff;
        entry_d.pc_n  = bus.i_pc_ff + (bus.i_cpsr_ff_t ? 32'd4 : 32'd8);
        entry_d.taken = bus.i_taken;
        entry_d.pred  = bus.i_pred;
    end

    // Next-state for pointers, occupancy and the post-abort sleep flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sleep_d  = sleep_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            sleep_d  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (bus.i_instr_abort) begin
                    sleep_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers; reset overrides every other input.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sleep_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sleep_q  <= sleep_d;
        end
    end

    // Entry storage; contents are not reset, only the pointers are.
    always_ff @(posedge i_clk) begin
        if (push && !i_reset) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    // Head entry falls through; abort is gated so stale storage never shows.
    assign head               = mem_q[rd_ptr_q];
    assign bus.o_valid        = !empty;
    assign bus.o_count        = count_q;
    assign bus.o_fetch_hold   = full | sleep_q;
    assign bus.o_instruction  = head.instr;
    assign bus.o_instr_abort  = head.abort & !empty;
    assign bus.o_pc_ff        = head.pc;
    assign bus.o_pc_plus_8_ff = head.pc_n;
    assign bus.o_taken        = head.taken;
    assign bus.o_pred         = head.pred;
endmodule

// File: tb/tb_zap_fetch_queue.sv
// Bench for zap_fetch_queue: a queue-based reference model checked on every
// negative clock edge, plus literal expectations at directed points.
module tb_zap_fetch_queue;
    localparam int DEPTH  = 4;
    localparam int PRED_W = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zap_fetch_queue_if #(.DEPTH(DEPTH), .PRED_W(PRED_W)) bus ();

    zap_fetch_queue #(.DEPTH(DEPTH), .PRED_W(PRED_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic        abort;
        logic [31:0] pc;
        logic [31:0] pcn;
        logic [1:0]  taken;
        logic [32:0] pred;
    } ent_t;

    ent_t mq[$];
    bit   msleep = 0;
    bit   m_flush, m_stall, m_pop, m_push;
    ent_t m_e;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            msleep = 0;
        end else begin
            m_stall = bus.i_data_stall || bus.i_stall_from_shifter ||
                      bus.i_stall_from_issue || bus.i_stall_from_decode;
            m_flush = bus.i_clear_from_writeback ||
                      (!bus.i_data_stall && bus.i_clear_from_alu) ||
                      (!m_stall && bus.i_clear_from_decode);
            if (m_flush) begin
                mq.delete();
                msleep = 0;
            end else begin
                m_pop  = !m_stall && mq.size() != 0;
                m_push = bus.i_valid && !msleep && mq.size() < DEPTH;
                if (m_push) begin
                    m_e.instr = bus.i_pc_ff[1] ? (bus.i_instruction >> 16) : bus.i_instruction;
                    m_e.abort = bus.i_instr_abort ||
                        (!bus.i_cpsr_ff_t && bus.i_instruction[31:20] == 12'hE12 &&
                         bus.i_instruction[7:4] == 4'h7) ||
                        (bus.i_cpsr_ff_t && m_e.instr[15:8] == 8'hBE);
                    m_e.pc    = bus.i_pc_ff;
                    m_e.pcn   = bus.i_pc_ff + (bus.i_cpsr_ff_t ? 32'd4 : 32'd8);
                    m_e.taken = bus.i_taken;
                    m_e.pred  = bus.i_pred;
                    if (bus.i_instr_abort) msleep = 1;
                end
                if (m_pop) void'(mq.pop_front());
                if (m_push) mq.push_back(m_e);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_count", 64'(bus.o_count), 64'(mq.size()));
            chk("m_valid", 64'(bus.o_valid), 64'(mq.size() != 0));
            chk("m_hold",  64'(bus.o_fetch_hold), 64'(mq.size() == DEPTH || msleep));
            if (mq.size() != 0) begin
                chk("m_instr", 64'(bus.o_instruction), 64'(mq[0].instr));
                chk("m_abort", 64'(bus.o_instr_abort), 64'(mq[0].abort));
                chk("m_pc",    64'(bus.o_pc_ff), 64'(mq[0].pc));
                chk("m_pcn",   64'(bus.o_pc_plus_8_ff), 64'(mq[0].pcn));
                chk("m_taken", 64'(bus.o_taken), 64'(mq[0].taken));
                chk("m_pred",  64'(bus.o_pred), 64'(mq[0].pred));
            end else begin
                chk("m_abort_idle", 64'(bus.o_instr_abort), 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] ins,
                         input logic t, input logic ab);
        bus.i_valid       = 1'b1;
        bus.i_pc_ff       = pc;
        bus.i_instruction = ins;
        bus.i_cpsr_ff_t   = t;
        bus.i_instr_abort = ab;
        bus.i_taken       = pc[3:2];
        bus.i_pred        = {1'b1, pc};
    endtask

    task automatic idle();
        bus.i_valid       = 1'b0;
        bus.i_instr_abort = 1'b0;
    endtask

    initial begin
        bus.i_clear_from_writeback = 0;
        bus.i_data_stall           = 0;
        bus.i_clear_from_alu       = 0;
        bus.i_stall_from_shifter   = 0;
        bus.i_stall_from_issue     = 0;
        bus.i_stall_from_decode    = 0;
        bus.i_clear_from_decode    = 0;
        bus.i_pc_ff                = 0;
        bus.i_cpsr_ff_t            = 0;
        bus.i_instruction          = 0;
        bus.i_valid                = 0;
        bus.i_instr_abort          = 0;
        bus.i_taken                = 0;
        bus.i_pred                 = 0;

        // Reset state
        rst = 1;
        tick(); tick();
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_count", 64'(bus.o_count), 64'd0);
        chk("rst_hold",  64'(bus.o_fetch_hold), 64'd0);
        chk("rst_abort", 64'(bus.o_instr_abort), 64'd0);
        rst = 0;
        tick();
        $display("reset released");

        // 1: single ARM fetch, one-cycle latency, then popped
        fetch(32'h100, 32'hE3A00001, 0, 0);
        tick();
        idle();
        chk("t1_valid", 64'(bus.o_valid), 64'd1);
        chk("t1_pcn",   64'(bus.o_pc_plus_8_ff), 64'h108);
        chk("t1_count", 64'(bus.o_count), 64'd1);
        chk("t1_instr", 64'(bus.o_instruction), 64'hE3A00001);
        tick();
        chk("t1_popped", 64'(bus.o_valid), 64'd0);
        $display("txn1: single fetch and pop");

        // 2: fill under decode stall, extra fetch ignored, drain in order
        bus.i_stall_from_decode = 1;
        for (int i = 0; i < DEPTH; i++) begin
            fetch(32'h200 + 32'(4 * i), 32'hE1A00000 + 32'(i), 0, 0);
            tick();
        end
        chk("t2_full_count", 64'(bus.o_count), 64'(DEPTH));
        chk("t2_full_hold",  64'(bus.o_fetch_hold), 64'd1);
        fetch(32'h300, 32'hDEADBEEF, 0, 0);
        tick();
        idle();
        chk("t2_ignored", 64'(bus.o_count), 64'(DEPTH));
        chk("t2_head0",   64'(bus.o_pc_ff), 64'h200);
        bus.i_stall_from_decode = 0;
        tick();
        chk("t2_head1",  64'(bus.o_pc_ff), 64'h204);
        chk("t2_cnt3",   64'(bus.o_count), 64'd3);
        tick();
        chk("t2_head2",  64'(bus.o_instruction), 64'hE1A00002);
        tick(); tick();
        chk("t2_empty",  64'(bus.o_count), 64'd0);
        $display("txn2: fill, ignore overflow, drain");

        // 3: ALU clear masked by data stall, then effective
        bus.i_data_stall = 1;
        for (int i = 0; i < 3; i++) begin
            fetch(32'h400 + 32'(4 * i), 32'hE2800000 + 32'(i), 0, 0);
            tick();
        end
        idle();
        bus.i_clear_from_alu = 1;
        tick();
        chk("t3_masked", 64'(bus.o_count), 64'd3);
        bus.i_data_stall = 0;
        tick();
        chk("t3_flushed", 64'(bus.o_count), 64'd0);
        bus.i_clear_from_alu = 0;
        $display("txn3: alu clear vs data stall");

        // 4: Thumb BKPT in upper halfword
        fetch(32'h202, 32'hBE01_0000, 1, 0);
        tick();
        idle();
        chk("t4_instr", 64'(bus.o_instruction[15:0]), 64'hBE01);
        chk("t4_abort", 64'(bus.o_instr_abort), 64'd1);
        chk("t4_pcn",   64'(bus.o_pc_plus_8_ff), 64'h206);
        chk("t4_hold",  64'(bus.o_fetch_hold), 64'd0);
        tick();
        // ARM BKPT also tags without sleeping
        fetch(32'h500, 32'hE120_0070, 0, 0);
        tick();
        idle();
        chk("t4_arm_bkpt", 64'(bus.o_instr_abort), 64'd1);
        chk("t4_arm_hold", 64'(bus.o_fetch_hold), 64'd0);
        tick();
        $display("txn4: thumb and arm bkpt tagging");

        // 5: instruction abort puts the queue to sleep until writeback clear
        bus.i_stall_from_decode = 1;
        fetch(32'h600, 32'hE3A01002, 0, 0);
        tick();
        fetch(32'h604, 32'hE3A01003, 0, 1);
        tick();
        chk("t5_hold",  64'(bus.o_fetch_hold), 64'd1);
        chk("t5_count", 64'(bus.o_count), 64'd2);
        fetch(32'h608, 32'hE3A01004, 0, 0);
        tick();
        chk("t5_ignored", 64'(bus.o_count), 64'd2);
        chk("t5_head_ok", 64'(bus.o_instr_abort), 64'd0);
        bus.i_stall_from_decode = 0;
        tick();
        chk("t5_head_ab", 64'(bus.o_instr_abort), 64'd1);
        chk("t5_head_pc", 64'(bus.o_pc_ff), 64'h604);
        tick();
        chk("t5_sleep", 64'(bus.o_fetch_hold), 64'd1);
        chk("t5_drained", 64'(bus.o_count), 64'd0);
        bus.i_clear_from_writeback = 1;
        tick();
        bus.i_clear_from_writeback = 0;
        idle();
        chk("t5_wake_hold",  64'(bus.o_fetch_hold), 64'd0);
        chk("t5_wake_count", 64'(bus.o_count), 64'd0);
        $display("txn5: abort sleep and writeback clear");

        // 6: simultaneous push/pop at count 2, wr_ptr wraps
        bus.i_stall_from_decode = 1;
        fetch(32'h700, 32'hE0000000, 0, 0); tick();
        fetch(32'h704, 32'hE0000001, 0, 0); tick();
        bus.i_stall_from_decode = 0;
        for (int i = 2; i < 8; i++) begin
            fetch(32'h700 + 32'(4 * i), 32'hE0000000 + 32'(i), 0, 0);
            tick();
            chk("t6_steady", 64'(bus.o_count), 64'd2);
        end
        idle();
        chk("t6_head", 64'(bus.o_pc_ff), 64'h718);
        tick();
        chk("t6_next", 64'(bus.o_instruction), 64'hE0000007);
        tick();
        $display("txn6: sustained push/pop with wrap");

        // 7: decode clear ignored while stalled; reset overrides mid-flight
        bus.i_stall_from_issue = 1;
        fetch(32'h800, 32'hE3A02000, 0, 0); tick();
        idle();
        bus.i_clear_from_decode = 1;
        tick();
        chk("t7_dec_masked", 64'(bus.o_count), 64'd1);
        bus.i_clear_from_decode = 0;
        fetch(32'h804, 32'hE3A02001, 0, 1);
        rst = 1;
        tick();
        rst = 0;
        idle();
        bus.i_stall_from_issue = 0;
        chk("t7_rst_count", 64'(bus.o_count), 64'd0);
        chk("t7_rst_hold",  64'(bus.o_fetch_hold), 64'd0);
        tick();
        $display("txn7: decode clear masked, reset mid-operation");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/zap_fetch_queue.md
# zap_fetch_queue

Parametrised, decoupled instruction fetch stage sitting between the I-cache/MMU and the decode stage. It buffers up to DEPTH fetched instructions with their PC, prediction bits and abort tags, and keeps the existing stall/clear priority ordering. It performs Thumb halfword alignment and BKPT-to-prefetch-abort tagging at enqueue time. It back-pressures the cache when full or sleeping, instead of dropping or overwriting data.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- PRED_W, 33: width of carried prediction word.
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_clear_from_writeback  in  1  flush, highest priority.
- i_data_stall  in  1  hold.
- i_clear_from_alu  in  1  flush.
- i_stall_from_shifter / i_stall_from_issue / i_stall_from_decode  in  1 each  hold.
- i_clear_from_decode  in  1  flush, lowest priority.
- i_pc_ff  in  32  PC of the incoming fetch.
- i_cpsr_ff_t  in  1  Thumb state.
- i_instruction  in  32  cache data.
- i_valid  in  1  cache data valid.
- i_instr_abort  in  1  instruction abort; qualified by i_valid.
- i_taken  in  2  branch-state RAM output for this fetch.
- i_pred  in  PRED_W  predicted target word.
- o_fetch_hold  out  1  cache must not advance; high when count==DEPTH or sleep_ff.
- o_count  out  $clog2(DEPTH)+1  occupancy.
- o_valid  out  1  head entry valid (count≠0).
- o_instruction  out  32  head instruction, already halfword-aligned.
- o_instr_abort  out  1  head abort tag.
- o_pc_ff  out  32  head PC.
- o_pc_plus_8_ff  out  32  head PC+8 (ARM) or PC+4 (Thumb).
- o_taken  out  2  head prediction state.
- o_pred  out  PRED_W  head prediction word.

## Operation
- Storage: circular array of DEPTH entries {instr, abort, pc, pc+N, taken, pred}; wr_ptr, rd_ptr, count all flops; outputs come from the head entry (first-word-fall-through); out-of-range array contents are don't-care when o_valid=0.
- Reset: count=0, pointers=0, sleep_ff=0, o_valid=0, o_instr_abort=0, o_fetch_hold=0, o_count=0; the array is not reset.
- Flush condition F: i_clear_from_writeback, or (!i_data_stall and i_clear_from_alu), or (no data/shifter/issue/decode stall and i_clear_from_decode).
- Hold condition H: !F and any of data/shifter/issue/decode stall.
- F: count=0, pointers=0, sleep_ff=0; no push and no pop that cycle.
- Pop: !F, !H, count≠0 → rd_ptr+1 mod DEPTH.
- Push: !F, i_valid, !sleep_ff, count<DEPTH → write entry at wr_ptr, wr_ptr+1 mod DEPTH. Push is independent of H, because the queue decouples the stages. A push when count==DEPTH is a protocol violation by the cache and is ignored.
- Simultaneous push and pop: count unchanged. Push into an empty queue while popping is impossible, because pop requires count≠0.
- Entry formation:
  - instr = i_pc_ff[1] ? i_instruction>>16 : i_instruction.
  - pc+N = i_pc_ff + (T ? 4 : 8), modulo 2^32.
  - abort = i_instr_abort, or (ARM and i_instruction matches BKPT), or (Thumb and the selected halfword matches T_BKPT).
- Sleep: a push whose i_instr_abort=1 sets sleep_ff. While asleep, i_valid is ignored and o_fetch_hold=1. Only F clears sleep_ff. Entries queued before the abort still drain normally. A BKPT-only abort does not set sleep_ff.

## Timing
- Enqueue-to-output latency is 1 cycle: pushed in cycle N, visible at the head in N+1 if the queue was empty.
- Dequeue: the head advances at the edge where pop is true; the next entry is visible in the following cycle.
- o_fetch_hold and o_count are registered state only; there is no combinational path from stall or clear inputs.
- Throughput is one push and one pop per cycle sustained at any occupancy below DEPTH.
- Reset asserted mid-operation overrides every other input in that cycle.

## Test plan
- Reset, then push 0xE3A00001 at PC 0x100 (ARM) → next cycle o_valid=1, o_pc_plus_8_ff=0x108, o_count=1; pop it → o_valid=0.
- Hold i_stall_from_decode=1 and push DEPTH entries → o_count=DEPTH, o_fetch_hold=1, and the extra i_valid is ignored; release the stall → entries emerge in order, one per cycle.
- Push three entries, then i_clear_from_alu with i_data_stall=1 → no flush, count=3; drop the stall with clear still high → count=0 next cycle.
- Thumb, PC 0x202, instruction 0xBE01_0000 → o_instruction[15:0]=0xBE01, o_instr_abort=1, o_pc_plus_8_ff=0x206, sleep_ff stays 0.
- i_instr_abort=1 at the second push → the second entry has the abort tag, o_fetch_hold=1, and later i_valid is ignored; i_clear_from_writeback → count=0, o_fetch_hold=0.
- Simultaneous push and pop at count=2 → count stays 2; push wraps wr_ptr from DEPTH-1 to 0 and the data stays in order.
